// File: rtl/riscv_test_pkg.sv
// Shared state encoding, register offsets and completion codes for the tohost monitor.
package riscv_test_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_PASS    = 2'd1,
    ST_FAIL    = 2'd2,
    ST_TIMEOUT = 2'd3
  } state_t;

  localparam logic [4:0] OFF_TOHOST = 5'h00;
  localparam logic [4:0] OFF_STATUS = 5'h08;
  localparam logic [4:0] OFF_CYCLE  = 5'h10;
  localparam logic [4:0] OFF_RETIRE = 5'h18;

  localparam logic [31:0] PASS_CODE = 32'h1;

endpackage

// File: rtl/riscv_test_monitor_sat_counter.sv
// Up-counter that stops at all-ones and holds while frozen.
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         freeze,
  output logic [W-1:0] count
);

  // Count enabled events, never wrapping past all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (en && !freeze && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/riscv_test_monitor.sv
// riscv-tests tohost responder: decodes the completion word into a sticky
// verdict, runs a cycle watchdog and counts retired instructions.
module riscv_test_monitor
  import riscv_test_pkg::*;
#(
  parameter int unsigned              ADDR_W         = 32,
  parameter logic [ADDR_W-1:0]        BASE_ADDR      = 32'h0000_1000,
  parameter int unsigned              TIMEOUT_CYCLES = 1_000_000,
  parameter int unsigned              CNT_W          = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_be,
  input  logic [63:0]       wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [63:0]       rd_data,
  output logic              rd_valid,
  input  logic              inst_retire,
  output logic              test_done,
  output logic              test_pass,
  output logic              test_timeout,
  output logic [31:0]       fail_testnum,
  output logic [CNT_W-1:0]  cycle_count
);

  state_t            state_q, state_d;
  logic [31:0]       tohost_q;
  logic [CNT_W-1:0]  retire_count;
  logic              run;
  logic              wr_hit;
  logic [31:0]       wv;
  logic              expire;
  logic [ADDR_W-1:0] rd_off;
  logic              rd_in_win;
  logic [63:0]       rd_sel;
  logic              unused_bits;

  assign unused_bits = ^{wr_data[63:32], wr_be[7:4]};

  assign run    = (state_q == ST_RUN);
  assign wv     = wr_data[31:0];
  assign wr_hit = wr_en && (wr_addr == BASE_ADDR) && (wr_be[3:0] == 4'hF) && run;
  assign expire = (cycle_count == CNT_W'(TIMEOUT_CYCLES - 1));

  assign test_done    = (state_q != ST_RUN);
  assign test_pass    = (state_q == ST_PASS);
  assign test_timeout = (state_q == ST_TIMEOUT);

  // Verdict state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_RUN;
    else     state_q <= state_d;
  end

  // Completion write beats watchdog expiry when both land on the same cycle.
  always_comb begin
    state_d = state_q;
    if (state_q == ST_RUN) begin
      if (wr_hit && wv[0]) state_d = (wv == PASS_CODE) ? ST_PASS : ST_FAIL;
      else if (expire)     state_d = ST_TIMEOUT;
    end
  end

  // Capture accepted tohost words and the failing test number.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tohost_q     <= '0;
      fail_testnum <= '0;
    end else if (wr_hit) begin
      tohost_q <= wv;
      if (wv[0] && (wv != PASS_CODE)) fail_testnum <= {1'b0, wv[31:1]};
    end
  end

  sat_counter #(.W(CNT_W)) u_cycle (
    .clk    (clk),
    .rst    (rst),
    .en     (1'b1),
    .freeze (!run),
    .count  (cycle_count)
  );

  sat_counter #(.W(CNT_W)) u_retire (
    .clk    (clk),
    .rst    (rst),
    .en     (inst_retire),
    .freeze (!run),
    .count  (retire_count)
  );

  // Out-of-window addresses wrap to large offsets, so one compare covers both sides.
  assign rd_off    = rd_addr - BASE_ADDR;
  assign rd_in_win = (rd_off < ADDR_W'(32));

  // Register read mux; unaligned offsets inside the window read as zero.
  always_comb begin
    rd_sel = '0;
    case (rd_off[4:0])
      OFF_TOHOST: rd_sel = {32'b0, tohost_q};
      OFF_STATUS: rd_sel = {59'b0, test_timeout, (state_q == ST_FAIL), test_pass, test_done, run};
      OFF_CYCLE:  rd_sel = 64'(cycle_count);
      OFF_RETIRE: rd_sel = 64'(retire_count);
      default:    rd_sel = '0;
    endcase
  end

  // Registered read response; rd_data holds between reads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en && rd_in_win;
      if (rd_en && rd_in_win) rd_data <= rd_sel;
    end
  end

endmodule

// File: tb/tb_riscv_test_monitor.sv
// Self-checking bench for riscv_test_monitor with a short watchdog.
module tb_riscv_test_monitor;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned CNT_W  = 32;
  localparam logic [31:0] BASE   = 32'h0000_1000;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              wr_en = 1'b0;
  logic [ADDR_W-1:0] wr_addr = '0;
  logic [7:0]        wr_be = '0;
  logic [63:0]       wr_data = '0;
  logic              rd_en = 1'b0;
  logic [ADDR_W-1:0] rd_addr = '0;
  logic [63:0]       rd_data;
  logic              rd_valid;
  logic              inst_retire = 1'b0;
  logic              test_done, test_pass, test_timeout;
  logic [31:0]       fail_testnum;
  logic [CNT_W-1:0]  cycle_count;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];

  riscv_test_monitor #(
    .ADDR_W         (ADDR_W),
    .BASE_ADDR      (BASE),
    .TIMEOUT_CYCLES (16),
    .CNT_W          (CNT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_be        (wr_be),
    .wr_data      (wr_data),
    .rd_en        (rd_en),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .inst_retire  (inst_retire),
    .test_done    (test_done),
    .test_pass    (test_pass),
    .test_timeout (test_timeout),
    .fail_testnum (fail_testnum),
    .cycle_count  (cycle_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Read scoreboard: every response must match the oldest outstanding expectation.
  always @(posedge clk) begin : mon
    logic [63:0] e;
    #1;
    if (rd_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rd_valid: got rd_data %0h expected no response", rd_data);
      end else begin
        e = exp_q.pop_front();
        check("rd_data", rd_data, e);
      end
    end
  end

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] off, input logic [7:0] be, input logic [63:0] d);
    wr_en = 1'b1; wr_addr = BASE + off; wr_be = be; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0; wr_be = '0; wr_data = '0;
  endtask

  task automatic do_read(input logic [31:0] off, input bit expect_resp, input logic [63:0] exp);
    rd_en = 1'b1; rd_addr = BASE + off;
    if (expect_resp) exp_q.push_back(exp);
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  task automatic check_verdict(input string tag, input logic done, input logic pass,
                               input logic tmo, input logic [31:0] num);
    check({tag, ".done"}, 64'(test_done), 64'(done));
    check({tag, ".pass"}, 64'(test_pass), 64'(pass));
    check({tag, ".timeout"}, 64'(test_timeout), 64'(tmo));
    check({tag, ".testnum"}, 64'(fail_testnum), 64'(num));
  endtask

  typedef struct {
    logic [31:0] off;
    logic [7:0]  be;
    logic [63:0] data;
    logic        done;
    logic        pass;
    logic [31:0] num;
  } vec_t;

  vec_t vecs[9];

  initial begin : watchdog
    #200000;
    $display("FAIL global_timeout: got no finish expected finish before 200000");
    $fatal(1, "bench timeout");
  end

  initial begin
    vecs[0] = '{32'h00, 8'hFF, 64'h1,                   1'b1, 1'b1, 32'd0};
    vecs[1] = '{32'h00, 8'hFF, 64'h7,                   1'b1, 1'b0, 32'd3};
    vecs[2] = '{32'h00, 8'h0F, 64'hFFFF_FFFF_0000_0001, 1'b1, 1'b1, 32'd0};
    vecs[3] = '{32'h00, 8'hF0, 64'h1,                   1'b0, 1'b0, 32'd0};
    vecs[4] = '{32'h00, 8'h07, 64'h1,                   1'b0, 1'b0, 32'd0};
    vecs[5] = '{32'h08, 8'hFF, 64'h1,                   1'b0, 1'b0, 32'd0};
    vecs[6] = '{32'h00, 8'hFF, 64'h10,                  1'b0, 1'b0, 32'd0};
    vecs[7] = '{32'h00, 8'hFF, 64'hFFFF_FFFF,           1'b1, 1'b0, 32'h7FFF_FFFF};
    vecs[8] = '{32'h04, 8'hFF, 64'h1,                   1'b0, 1'b0, 32'd0};

    // Reset state
    apply_reset();
    check_verdict("reset", 1'b0, 1'b0, 1'b0, 32'd0);
    check("reset.cycle", 64'(cycle_count), 64'd0);
    check("reset.rd_valid", 64'(rd_valid), 64'd0);
    check("reset.rd_data", rd_data, 64'd0);

    // Write decode table
    for (int i = 0; i < 9; i++) begin
      apply_reset();
      do_write(vecs[i].off, vecs[i].be, vecs[i].data);
      check_verdict($sformatf("vec%0d", i), vecs[i].done, vecs[i].pass, 1'b0, vecs[i].num);
    end

    // PASS freezes the cycle counter
    apply_reset();
    do_write(32'h00, 8'hFF, 64'h1);
    check("pass.cycle", 64'(cycle_count), 64'd1);
    repeat (4) @(negedge clk);
    check("pass.cycle_frozen", 64'(cycle_count), 64'd1);

    // FAIL is terminal; a later PASS code is ignored
    apply_reset();
    do_write(32'h00, 8'hFF, 64'h7);
    do_write(32'h00, 8'hFF, 64'h1);
    check_verdict("fail_sticky", 1'b1, 1'b0, 1'b0, 32'd3);
    do_read(32'h08, 1'b1, 64'h0A);

    // Syscall word, readback, read/write collision, window edges
    apply_reset();
    do_write(32'h00, 8'hFF, 64'h10);
    check_verdict("syscall", 1'b0, 1'b0, 1'b0, 32'd0);
    do_read(32'h00, 1'b1, 64'h10);
    do_read(32'h08, 1'b1, 64'h01);
    rd_en = 1'b1; rd_addr = BASE; exp_q.push_back(64'h10);
    do_write(32'h00, 8'hFF, 64'h20);
    rd_en = 1'b0;
    do_read(32'h04, 1'b1, 64'h0);
    do_read(32'h00, 1'b1, 64'h20);
    do_read(32'h20, 1'b0, 64'h0);
    rd_en = 1'b1; rd_addr = BASE - 32'h8;
    @(negedge clk);
    rd_en = 1'b0;
    repeat (2) @(negedge clk);
    check("rd_data_hold", rd_data, 64'h20);

    // Watchdog expiry
    apply_reset();
    repeat (15) @(negedge clk);
    check("wd.before", 64'(test_timeout), 64'd0);
    check("wd.cycle15", 64'(cycle_count), 64'd15);
    @(negedge clk);
    check_verdict("wd.expired", 1'b1, 1'b0, 1'b1, 32'd0);
    check("wd.cycle16", 64'(cycle_count), 64'd16);
    repeat (3) @(negedge clk);
    do_write(32'h00, 8'hFF, 64'h1);
    check_verdict("wd.sticky", 1'b1, 1'b0, 1'b1, 32'd0);
    check("wd.cycle_frozen", 64'(cycle_count), 64'd16);
    do_read(32'h08, 1'b1, 64'h12);

    // Completion write on the expiry cycle wins
    apply_reset();
    repeat (15) @(negedge clk);
    do_write(32'h00, 8'hFF, 64'h1);
    check_verdict("wd.race", 1'b1, 1'b1, 1'b0, 32'd0);
    check("wd.race_cycle", 64'(cycle_count), 64'd16);

    // Retire counting stops at the verdict
    apply_reset();
    inst_retire = 1'b1;
    repeat (10) @(negedge clk);
    inst_retire = 1'b0;
    do_write(32'h00, 8'hFF, 64'h1);
    inst_retire = 1'b1;
    repeat (5) @(negedge clk);
    inst_retire = 1'b0;
    do_read(32'h18, 1'b1, 64'd10);
    do_read(32'h08, 1'b1, 64'h06);
    do_read(32'h10, 1'b1, 64'd11);

    // Reset mid-RUN clears asynchronously and restarts counting
    apply_reset();
    repeat (3) @(negedge clk);
    do_read(32'h10, 1'b1, 64'd3);
    @(negedge clk);
    check("midrst.cycle_before", 64'(cycle_count), 64'd5);
    check("midrst.rd_data_before", rd_data, 64'd3);
    rst = 1'b1;
    #1;
    check("midrst.cycle_async", 64'(cycle_count), 64'd0);
    check("midrst.rd_data_async", rd_data, 64'd0);
    check_verdict("midrst.async", 1'b0, 1'b0, 1'b0, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("midrst.restart", 64'(cycle_count), 64'd2);
    do_write(32'h00, 8'hFF, 64'h1);
    check_verdict("midrst.pass", 1'b1, 1'b1, 1'b0, 32'd0);

    // All expected read responses must have arrived
    for (int k = 0; k < 8; k++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    check("read_drain", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
